// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB steps.
// Ports: opcode/zero/mem_ready in; datapath controls, retire, fault, state out.
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int WAIT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ir_write,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic       link,
   output logic       jalfor,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       retire,
   output logic [1:0] fault,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_R      = 6'b110000;
   localparam logic [5:0] OP_LW     = 6'b110001;
   localparam logic [5:0] OP_SW     = 6'b110010;
   localparam logic [5:0] OP_BEQ    = 6'b110011;
   localparam logic [5:0] OP_BNE    = 6'b110100;
   localparam logic [5:0] OP_ADDI   = 6'b110101;
   localparam logic [5:0] OP_J      = 6'b110110;
   localparam logic [5:0] OP_JAL    = 6'b110111;
   localparam logic [5:0] OP_JALFOR = 6'b111000;

   state_t              st;
   logic [5:0]          op_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                in_wait;
   logic                timeout;

   assign in_wait = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
   // Ready in the same cycle beats the timeout.
   assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready &&
                    (wait_cnt == WAIT_W'(MEM_TIMEOUT));

   assign state = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= S_IDLE;
         op_q     <= '0;
         wait_cnt <= '0;
         fault    <= 2'b00;
      end else begin
         // Leaving a wait state clears the counter, so every entry starts at 0.
         if (in_wait && !mem_ready) begin
            if (wait_cnt != '1)
               wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end

         if (timeout) begin
            st    <= S_TRAP;
            fault <= 2'b10;
         end else begin
            case (st)
               S_IDLE:     st <= S_FETCH;
               S_FETCH:    if (mem_ready) st <= S_DECODE;
               S_DECODE: begin
                  op_q <= opcode;
                  case (opcode)
                     OP_LW, OP_SW:             st <= S_MEM_ADDR;
                     OP_R, OP_ADDI:            st <= S_EXEC;
                     OP_BEQ, OP_BNE:           st <= S_BRANCH;
                     OP_J, OP_JAL, OP_JALFOR:  st <= S_JUMP;
                     default: begin
                        st    <= S_TRAP;
                        fault <= 2'b01;
                     end
                  endcase
               end
               S_MEM_ADDR: st <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
               S_MEM_RD:   if (mem_ready) st <= S_MEM_WB;
               S_MEM_WB:   st <= S_FETCH;
               S_MEM_WR:   if (mem_ready) st <= S_FETCH;
               S_EXEC:     st <= S_ALU_WB;
               S_ALU_WB:   st <= S_FETCH;
               S_BRANCH:   st <= S_FETCH;
               S_JUMP:     st <= S_FETCH;
               S_TRAP:     st <= S_TRAP;
               default:    st <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      link       = 1'b0;
      jalfor     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      pc_source  = 2'b00;
      retire     = 1'b0;
      case (st)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = (op_q == OP_R) ? 2'b00 : 2'b10;
            alu_op    = (op_q == OP_R) ? 3'b010 : 3'b000;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            reg_dst   = (op_q == OP_R) ? 2'b01 : 2'b00;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b001;
            pc_source = 2'b01;
            retire    = 1'b1;
            pc_en     = (op_q == OP_BEQ) ? zero : ~zero;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_en     = 1'b1;
            retire    = 1'b1;
            if (op_q == OP_JAL || op_q == OP_JALFOR) begin
               reg_write = 1'b1;
               reg_dst   = 2'b10;
               link      = 1'b1;
            end
            jalfor = (op_q == OP_JALFOR);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: scoreboard of retirements plus
// directed trap, timeout and reset checks.
module tb_multicycle_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_en, ir_write, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_write, link, jalfor, alu_src_a, retire;
   logic [1:0] reg_dst, alu_src_b, pc_source, fault;
   logic [2:0] alu_op;
   logic [3:0] state;

   multicycle_sequencer dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
      .link(link), .jalfor(jalfor), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .retire(retire), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   wire [19:0] ctl = {pc_en, ir_write, i_or_d, mem_read, mem_write,
                      mem_to_reg, reg_write, reg_dst, link, jalfor,
                      alu_src_a, alu_src_b, alu_op, pc_source, retire};

   typedef struct packed {
      logic       pc_en;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       link;
      logic       jalfor;
      logic       mem_to_reg;
      logic [1:0] pc_source;
   } sig_t;

   localparam logic [5:0] OP_R = 6'b110000, OP_LW = 6'b110001,
      OP_SW = 6'b110010, OP_BEQ = 6'b110011, OP_BNE = 6'b110100,
      OP_ADDI = 6'b110101, OP_J = 6'b110110, OP_JAL = 6'b110111,
      OP_JALFOR = 6'b111000;

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   exp_cyc_q[$];
   sig_t exp_sig_q[$];
   logic trace_on = 1'b0;
   int   st_tr[$];
   int   aop_tr[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                    name, act, exp, cyc);
   endtask

   // Architectural view of what each instruction does in its last cycle.
   function automatic sig_t exp_sig(input logic [5:0] op, input logic z);
      sig_t s;
      s = '0;
      case (op)
         OP_R:      begin s.reg_write = 1; s.reg_dst = 2'b01; end
         OP_ADDI:   s.reg_write = 1;
         OP_LW:     begin s.reg_write = 1; s.mem_to_reg = 1; end
         OP_SW:     ;
         OP_BEQ:    begin s.pc_en = z; s.pc_source = 2'b01; end
         OP_BNE:    begin s.pc_en = !z; s.pc_source = 2'b01; end
         OP_J:      begin s.pc_en = 1; s.pc_source = 2'b10; end
         OP_JAL, OP_JALFOR: begin
            s.pc_en = 1; s.pc_source = 2'b10; s.reg_write = 1;
            s.reg_dst = 2'b10; s.link = 1; s.jalfor = (op == OP_JALFOR);
         end
         default: ;
      endcase
      return s;
   endfunction

   function automatic int base_len(input logic [5:0] op);
      case (op)
         OP_R, OP_ADDI, OP_SW: return 4;
         OP_LW:                return 5;
         default:              return 3;
      endcase
   endfunction

   // Issue one instruction starting in FETCH; wf fetch waits, wm memory waits.
   task automatic run_instr(input logic [5:0] op, input logic z,
                            input int wf, input int wm);
      bit is_mem;
      int len;
      int ms;
      is_mem = (op == OP_LW) || (op == OP_SW);
      if (!is_mem) wm = 0;
      len = base_len(op) + wf + wm;
      ms  = wf + 3;
      exp_cyc_q.push_back(cyc + len - 1);
      exp_sig_q.push_back(exp_sig(op, z));
      for (int k = 0; k < len; k++) begin
         opcode = op;
         zero   = z;
         if (k < wf) mem_ready = 1'b0;
         else if (k == wf) mem_ready = 1'b1;
         else if (is_mem && k >= ms && k < ms + wm) mem_ready = 1'b0;
         else if (is_mem && k == ms + wm) mem_ready = 1'b1;
         else mem_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT retires.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read && mem_write)
            chk("rd_wr_excl", 1, 0);
         if (trace_on) begin
            st_tr.push_back(int'(state));
            aop_tr.push_back(int'(alu_op));
         end
         if (retire) begin
            chk("retire_no_fault", int'(fault), 0);
            if (exp_cyc_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_retire: retire at cycle %0d", cyc);
            end else begin
               chk("retire_cycle", cyc, exp_cyc_q.pop_front());
               chk("retire_ctl",
                   int'({pc_en, reg_write, reg_dst, link, jalfor,
                         mem_to_reg, pc_source}),
                   int'(exp_sig_q.pop_front()));
            end
         end
      end
   end

   task automatic release_reset();
      rst_n = 1'b1;
      #1;
      chk("idle_state", int'(state), 0);
      chk("idle_ctl", int'(ctl), 0);
      @(posedge clk);
      #1;
   endtask

   localparam logic [5:0] LEGAL [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ,
      OP_BNE, OP_ADDI, OP_J, OP_JAL, OP_JALFOR};

   initial begin
      logic [5:0] op;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", int'(state), 0);
      chk("reset_ctl", int'(ctl), 0);
      chk("reset_fault", int'(fault), 0);
      release_reset();

      trace_on = 1'b1;
      run_instr(OP_R, 1'b0, 0, 0);
      trace_on = 1'b0;
      chk("rtype_trace_len", st_tr.size(), 4);
      if (st_tr.size() == 4) begin
         chk("rtype_st0", st_tr[0], 1);
         chk("rtype_st1", st_tr[1], 2);
         chk("rtype_st2", st_tr[2], 7);
         chk("rtype_st3", st_tr[3], 8);
         chk("rtype_exec_aluop", aop_tr[2], 2);
      end
      chk("rtype_back_fetch", int'(state), 1);

      run_instr(OP_LW, 1'b0, 0, 3);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_BNE, 1'b1, 0, 0);
      run_instr(OP_JALFOR, 1'b0, 0, 0);
      run_instr(OP_SW, 1'b1, 2, 1);

      for (int i = 0; i < 60; i++) begin
         op = LEGAL[$urandom_range(0, 8)];
         run_instr(op, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                   $urandom_range(0, 4));
      end

      // Ready on the last permitted fetch cycle completes normally.
      run_instr(OP_J, 1'b0, 255, 0);

      // Illegal opcode traps and holds every control low.
      opcode = 6'b000000;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("illegal_decode", int'(state), 2);
      @(posedge clk); #1;
      chk("illegal_trap", int'(state), 11);
      chk("illegal_fault", int'(fault), 1);
      for (int i = 0; i < 10; i++) begin
         opcode = 6'($urandom);
         mem_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("trap_hold_ctl", int'(ctl), 0);
         chk("trap_hold_st", int'(state), 11);
         chk("trap_hold_fault", int'(fault), 1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_fault", int'(fault), 0);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      release_reset();
      run_instr(OP_ADDI, 1'b0, 1, 0);

      // Fetch starved of ready runs out its wait budget and traps.
      opcode = OP_J;
      mem_ready = 1'b0;
      repeat (255) @(posedge clk);
      #1;
      chk("timeout_last_fetch", int'(state), 1);
      chk("timeout_no_fault_yet", int'(fault), 0);
      @(posedge clk); #1;
      chk("timeout_trap", int'(state), 11);
      chk("timeout_fault", int'(fault), 2);
      chk("timeout_ctl", int'(ctl), 0);

      rst_n = 1'b0;
      #1;
      chk("final_rst_fault", int'(fault), 0);
      @(posedge clk); #1;
      chk("scoreboard_empty", exp_cyc_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
